// File: rtl/lfsr_prbs_checker_if.sv
// Serial PRBS receive bus and status outputs for lfsr_prbs_checker.
// Source drives the bit stream; the checker returns lock and error status.
interface lfsr_prbs_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_count;
    logic             locked;
    logic [1:0]       sync_state;
    logic             error_pulse;
    logic [CNT_W-1:0] error_count;
    logic [7:0]       hist_q;

    modport master (
        output bit_in, bit_valid, clear_count,
        input  locked, sync_state, error_pulse, error_count, hist_q
    );

    modport slave (
        input  bit_in, bit_valid, clear_count,
        output locked, sync_state, error_pulse, error_count, hist_q
    );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising checker for the 8-bit Fibonacci PRBS (s[n]=s[n-2]^s[n-3]^s[n-4]^s[n-8]).
// Define LFSR_CHECK_SATURATE_EN to saturate error_count instead of wrapping.
module lfsr_prbs_checker #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_THR = 4
) (
    input logic                clock,
    input logic                reset,
    lfsr_prbs_checker_if.slave bus
);
    typedef enum logic [1:0] {
        StSeed   = 2'b00,
        StHunt   = 2'b01,
        StLocked = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hist_q, hist_d;
    logic [2:0]       seed_cnt_q, seed_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_next;
    logic [7:0]       rx_hist;
    logic             expected;
    logic             mismatch;

    assign expected = hist_q[1] ^ hist_q[2] ^ hist_q[3] ^ hist_q[7];
    assign mismatch = bus.bit_in != expected;
    assign rx_hist  = {hist_q[6:0], bus.bit_in};

`ifdef LFSR_CHECK_SATURATE_EN
    assign err_next = (&err_cnt_q) ? err_cnt_q
                                   : err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`else
    assign err_next = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        if (bus.bit_valid) begin
            unique case (state_q)
                StSeed: begin
                    hist_d     = rx_hist;
                    seed_cnt_d = seed_cnt_q + 3'd1;
                    if (seed_cnt_q == 3'd7) begin
                        state_d     = StHunt;
                        match_cnt_d = '0;
                    end
                end
                StHunt: begin
                    hist_d = rx_hist;
                    // An all-zero history is self-consistent but is not the PRBS; never count it.
                    if (mismatch || rx_hist == 8'h00) begin
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        if (match_cnt_d == 8'(LOCK_CNT)) begin
                            state_d    = StLocked;
                            loss_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    // Flywheel: keep predicting from our own sequence so line errors do not propagate.
                    hist_d = {hist_q[6:0], expected};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = err_next;
                        loss_cnt_d  = loss_cnt_q + 4'd1;
                        if (loss_cnt_d == 4'(LOSS_THR)) begin
                            state_d     = StSeed;
                            seed_cnt_d  = '0;
                            match_cnt_d = '0;
                            loss_cnt_d  = '0;
                        end
                    end else begin
                        loss_cnt_d = '0;
                    end
                end
                default: state_d = StSeed;
            endcase
        end
        if (bus.clear_count) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StSeed;
            hist_q      <= 8'h00;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            loss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.locked      = state_q == StLocked;
    assign bus.sync_state  = state_q;
    assign bus.error_pulse = err_pulse_q;
    assign bus.error_count = err_cnt_q;
    assign bus.hist_q      = hist_q;
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: reference PRBS generator, per-bit expectation queue,
// a vector table for hold/clear corners, and a CNT_W=4 instance for overflow behaviour.
module tb_lfsr_prbs_checker;
    localparam logic [1:0] SEED = 2'b00;
    localparam logic [1:0] HUNT = 2'b01;
    localparam logic [1:0] LOCK = 2'b10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lfsr_prbs_checker_if #(.CNT_W(16)) bus ();
    lfsr_prbs_checker_if #(.CNT_W(4))  bus4 ();

    lfsr_prbs_checker #(.CNT_W(16), .LOCK_CNT(16), .LOSS_THR(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    lfsr_prbs_checker #(.CNT_W(4), .LOCK_CNT(16), .LOSS_THR(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.bit_in      = bus.bit_in;
    assign bus4.bit_valid   = bus.bit_valid;
    assign bus4.clear_count = bus.clear_count;

    typedef struct {
        string       name;
        bit          ck4;
        logic        locked;
        logic [1:0]  st;
        logic        pulse;
        logic [15:0] cnt;
        logic [7:0]  hist;
        logic [3:0]  cnt4;
    } exp_t;

    typedef struct {
        logic v;
        logic clr;
        logic flip;
        logic pulse;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  gen_q = 8'hA5;
    logic [7:0]  th    = 8'h00;
    logic [15:0] ecnt  = 16'd0;
    logic [3:0]  ecnt4 = 4'd0;
    bit          chk4  = 1'b0;
    bit          zero_mode = 1'b0;

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total = total + 1;
            if (bus.locked !== e.locked || bus.sync_state !== e.st ||
                bus.error_pulse !== e.pulse || bus.error_count !== e.cnt ||
                bus.hist_q !== e.hist || (e.ck4 && bus4.error_count !== e.cnt4)) begin
                bad = bad + 1;
                $display("FAIL %s: got lock=%b st=%b pulse=%b cnt=%0d hist=%h cnt4=%0d, want lock=%b st=%b pulse=%b cnt=%0d hist=%h cnt4=%0d(chk=%0d)",
                         e.name, bus.locked, bus.sync_state, bus.error_pulse, bus.error_count,
                         bus.hist_q, bus4.error_count, e.locked, e.st, e.pulse, e.cnt, e.hist,
                         e.cnt4, e.ck4);
            end
        end
    end

    function automatic logic [1:0] st_at(int n);
        return (n < 8) ? SEED : ((n < 24) ? HUNT : LOCK);
    endfunction

    task automatic drive(input logic r, input logic b, input logic v, input logic clr,
                         input exp_t e);
        @(negedge clock);
        reset           = r;
        bus.bit_in      = b;
        bus.bit_valid   = v;
        bus.clear_count = clr;
        sb.push_back(e);
    endtask

    // One cycle of stimulus; the bench tracks the true stream, history and both counters.
    task automatic gbit(input logic flip, input logic v, input logic clr, input logic elock,
                        input logic [1:0] est, input logic epulse, input string name);
        logic tb_bit;
        logic b;
        exp_t e;
        if (v) begin
            if (zero_mode) begin
                tb_bit = 1'b0;
            end else begin
                tb_bit = gen_q[0];
                gen_q  = {gen_q[6] ^ gen_q[5] ^ gen_q[4] ^ gen_q[0], gen_q[7:1]};
            end
            th = {th[6:0], tb_bit};
            b  = tb_bit ^ flip;
        end else begin
            b = 1'($urandom);
        end
        if (clr) begin
            ecnt  = 16'd0;
            ecnt4 = 4'd0;
        end else if (epulse) begin
            ecnt = ecnt + 16'd1;
`ifdef LFSR_CHECK_SATURATE_EN
            if (ecnt4 != 4'hF) ecnt4 = ecnt4 + 4'd1;
`else
            ecnt4 = ecnt4 + 4'd1;
`endif
        end
        e = '{name, chk4, elock, est, epulse, ecnt, th, ecnt4};
        drive(1'b0, b, v, clr, e);
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        th    = 8'h00;
        ecnt  = 16'd0;
        ecnt4 = 4'd0;
        e = '{name, chk4, 1'b0, SEED, 1'b0, 16'd0, 8'h00, 4'd0};
        drive(1'b1, 1'($urandom), 1'b1, 1'b0, e);
        drive(1'b1, 1'($urandom), 1'b1, 1'b0, e);
    endtask

    // Correct stream from SEED with continuous valid.
    task automatic sync_run(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            gbit(1'b0, 1'b1, 1'b0, (i >= 24), st_at(i), 1'b0, name);
        end
    endtask

    initial begin
        int vk;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.clear_count = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Acquisition and long clean run
        do_reset("reset");
        sync_run(1024, "acquire");

        // Single error: one pulse, flywheel keeps prediction intact
        gbit(1'b1, 1'b1, 1'b0, 1'b1, LOCK, 1'b1, "single_err");
        for (int i = 0; i < 300; i++) gbit(1'b0, 1'b1, 1'b0, 1'b1, LOCK, 1'b0, "flywheel");

        // Valid-low hold and clear_count corners while locked
        for (int i = 0; i < 11; i++) begin
            gbit(tbl[i].flip, tbl[i].v, tbl[i].clr, 1'b1, LOCK, tbl[i].pulse, "vec_table");
        end

        // Four consecutive errors drop lock, then relock
        for (int k = 1; k <= 4; k++) begin
            gbit(1'b1, 1'b1, 1'b0, (k < 4), (k < 4) ? LOCK : SEED, 1'b1, "loss");
        end
        sync_run(30, "relock");

        // All-zero stream must never lock
        do_reset("reset_zero");
        zero_mode = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            gbit(1'b0, 1'b1, 1'b0, 1'b0, (i < 8) ? SEED : HUNT, 1'b0, "zero_stream");
        end
        zero_mode = 1'b0;

        // Alternating valid: lock after 24 valid bits (48 cycles)
        do_reset("reset_toggle");
        vk = 0;
        for (int c = 0; c < 52; c++) begin
            if (c % 2 == 0) vk++;
            gbit(1'b0, (c % 2 == 0), 1'b0, (vk >= 24), st_at(vk), 1'b0, "valid_toggle");
        end

        // Reset mid-HUNT
        do_reset("reset_pre_hunt");
        sync_run(12, "hunt");
        do_reset("reset_mid_hunt");

        // Counter overflow on the CNT_W=4 instance, then clear coincident with an error
        chk4 = 1'b1;
        do_reset("reset_overflow");
        sync_run(30, "lock_for_overflow");
        for (int k = 0; k < 20; k++) begin
            gbit(1'b1, 1'b1, 1'b0, 1'b1, LOCK, 1'b1, "overflow_err");
            for (int j = 0; j < 9; j++) gbit(1'b0, 1'b1, 1'b0, 1'b1, LOCK, 1'b0, "overflow_gap");
        end
        gbit(1'b1, 1'b1, 1'b1, 1'b1, LOCK, 1'b1, "clear_with_err");
        for (int i = 0; i < 5; i++) gbit(1'b0, 1'b1, 1'b0, 1'b1, LOCK, 1'b0, "after_clear");

        @(posedge clock);
        #3;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
